// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit.
// CMD_CMP exists only when CMP_NOWRITE_EN is defined.
package mc_pkg;

  localparam int MC_STATE_W = 4;

  typedef enum logic [MC_STATE_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
`ifdef CMP_NOWRITE_EN
  localparam logic [3:0] CMD_CMP = 4'b1010;
`endif

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // flags are packed {N,Z,C,V}
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, res;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_cond_logic.sv
// Architectural flags, condition evaluation and strobe gating.
// The condition verdict is frozen when DECODE retires and gates all later strobes.
module mc_cond_logic
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       capture_i,
  input  logic       pcs_i,
  input  logic       next_pc_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_ex;

  always_comb begin
    cond_ex   = cond_holds(cond_i, flags_q);
    cond_ex_d = capture_i ? cond_ex : cond_ex_q;
    flags_d   = flags_q;
    // A failed condition leaves the flags untouched
    if (cond_ex_q) begin
      if (flag_w_i[1]) flags_d[3:2] = alu_flags_i[3:2];
      if (flag_w_i[0]) flags_d[1:0] = alu_flags_i[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign mem_write_o = mem_w_i & cond_ex_q;
  assign reg_write_o = reg_w_i & cond_ex_q & ~pcs_i;
  assign pc_write_o  = next_pc_i | (pcs_i & cond_ex_q);

endmodule

// File: rtl/mc_control_unit.sv
// Main FSM and decoders of the multicycle ARM-subset control unit.
// Define CMP_NOWRITE_EN to decode CMP as a flag-only SUB.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int STATE_W = MC_STATE_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  logic [STATE_W-1:0] state_q, state_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       unused_rn;

  // Instr carries bits [31:12], so local indices are offset by 12
  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign unused_rn = ^Instr[7:4];
  assign rd        = Instr[3:0];
  assign cmd       = funct[4:1];

  logic next_pc, reg_w, mem_w, branch, alu_op;
  logic no_write, reg_w_eff, pcs;
  logic [1:0] flag_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    next_pc   = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        state_d   = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (op)
          2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
        state_d   = FETCH;
      end
      MEMWR: begin
        AdrSrc  = 1'b1;
        mem_w   = 1'b1;
        state_d = FETCH;
      end
      EXECUTER: begin
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        alu_op  = 1'b1;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_w   = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      UNKNOWN: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Unsupported commands fall back to ADD and never touch the flags
  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (cmd)
        CMD_ADD: begin
          ALUControl = ALU_ADD;
          flag_w     = {funct[0], funct[0]};
        end
        CMD_SUB: begin
          ALUControl = ALU_SUB;
          flag_w     = {funct[0], funct[0]};
        end
        CMD_AND: begin
          ALUControl = ALU_AND;
          flag_w     = {funct[0], 1'b0};
        end
        CMD_ORR: begin
          ALUControl = ALU_ORR;
          flag_w     = {funct[0], 1'b0};
        end
`ifdef CMP_NOWRITE_EN
        CMD_CMP: begin
          ALUControl = ALU_SUB;
          flag_w     = 2'b11;
        end
`endif
        default: begin
          ALUControl = ALU_ADD;
          flag_w     = 2'b00;
        end
      endcase
    end
  end

`ifdef CMP_NOWRITE_EN
  // Memory ops can alias cmd=1010 through their P/U/B/W bits, so qualify on op
  assign no_write = (op == 2'b00) && (cmd == CMD_CMP);
`else
  assign no_write = 1'b0;
`endif

  assign reg_w_eff = reg_w & ~no_write;
  assign pcs       = ((rd == 4'hF) & reg_w_eff) | branch;

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

  mc_cond_logic u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (cond),
    .alu_flags_i (ALUFlags),
    .flag_w_i    (flag_w),
    .capture_i   (state_q == DECODE),
    .pcs_i       (pcs),
    .next_pc_i   (next_pc),
    .reg_w_i     (reg_w_eff),
    .mem_w_i     (mem_w),
    .pc_write_o  (PCWrite),
    .reg_write_o (RegWrite),
    .mem_write_o (MemWrite)
  );

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: an instruction-level model predicts every
// control output per cycle; literal checks pin key cycles and flag values.
module tb_mc_control_unit;

  logic        clk;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  mc_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .RegSrc     (RegSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,RegSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl}
  logic [15:0] got_vec;
  assign got_vec = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

  int          n_checks = 0;
  int          n_err    = 0;
  logic        exp_valid = 1'b0;
  logic [15:0] exp_vec;
  logic [3:0]  exp_flags;
  string       cur_name = "";
  int          cur_step = 0;
  logic [15:0] seen [0:4];
  logic [3:0]  m_flags = 4'b0000;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // ---------------- instruction-level model ----------------
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;          4'h1: return !z;
      4'h2: return cy;         4'h3: return !cy;
      4'h4: return n;          4'h5: return !n;
      4'h6: return v;          4'h7: return !v;
      4'h8: return cy && !z;   4'h9: return !cy || z;
      4'hA: return n == v;     4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] model_alu(input logic [3:0] cmd);
    if (cmd == 4'b0010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
`ifdef CMP_NOWRITE_EN
    if (cmd == 4'b1010) return 2'b01;
`endif
    return 2'b00;
  endfunction

  function automatic logic [1:0] model_flagw(input logic [5:0] funct);
    logic [3:0] cmd;
    cmd = funct[4:1];
    if (cmd == 4'b0100 || cmd == 4'b0010) return {funct[0], funct[0]};
    if (cmd == 4'b0000 || cmd == 4'b1100) return {funct[0], 1'b0};
`ifdef CMP_NOWRITE_EN
    if (cmd == 4'b1010) return 2'b11;
`endif
    return 2'b00;
  endfunction

  function automatic logic model_nowrite(input logic [5:0] funct);
`ifdef CMP_NOWRITE_EN
    return funct[4:1] == 4'b1010;
`else
    return funct[0] && 1'b0;
`endif
  endfunction

  function automatic int model_len(input logic [31:0] ins);
    case (ins[27:26])
      2'b00:   return 4;
      2'b01:   return ins[20] ? 5 : 4;
      default: return 3;
    endcase
  endfunction

  function automatic logic [15:0] model_ctrl(input logic [31:0] ins, input int s, input logic cx);
    logic [1:0] op, b, res, alu;
    logic [5:0] funct;
    logic       pc, mw, rw, ir, adr, a, rd_pc, wr;
    op = ins[27:26]; funct = ins[25:20]; rd_pc = (ins[15:12] == 4'hF);
    pc = 0; mw = 0; rw = 0; ir = 0; adr = 0; a = 0; b = 0; res = 0; alu = 0;
    if (s == 0) begin
      pc = 1; ir = 1; a = 1; b = 2; res = 2;
    end else if (s == 1) begin
      a = 1; b = 2; res = 2;
    end else if (op == 2'b00) begin
      if (s == 2) begin
        b = funct[5] ? 2'd1 : 2'd0;
        alu = model_alu(funct[4:1]);
      end else begin
        wr = cx && !model_nowrite(funct);
        rw = wr && !rd_pc;
        pc = wr && rd_pc;
      end
    end else if (op == 2'b01) begin
      if (s == 2) b = 1;
      else if (funct[0]) begin
        if (s == 3) adr = 1;
        else begin res = 1; rw = cx && !rd_pc; pc = cx && rd_pc; end
      end else begin
        adr = 1; mw = cx;
      end
    end else if (op == 2'b10) begin
      b = 1; res = 2; pc = cx;
    end
    return {pc, mw, rw, ir, adr, (op == 2'b01), (op == 2'b10), a, b, res, op, alu};
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (exp_valid) begin
      seen[cur_step] = got_vec;
      chk($sformatf("%s_s%0d_ctrl", cur_name, cur_step), got_vec, exp_vec);
      chk($sformatf("%s_s%0d_flags", cur_name, cur_step),
          {12'd0, dut.u_cond.flags_q}, {12'd0, exp_flags});
    end
  end

  // Entered right after the edge that puts the DUT in FETCH.
  task automatic run_instr(input string nm, input logic [31:0] ins,
                           input logic [3:0] af, input int abort_at);
    logic cx;
    logic [1:0] fw;
    int len;
    Instr = ins[31:12]; ALUFlags = af; cur_name = nm;
    cx  = cond_eval(ins[31:28], m_flags);
    len = model_len(ins);
    for (int i = 0; i < 5; i++) seen[i] = 16'h0;
    for (int s = 0; s < len; s++) begin
      exp_vec = model_ctrl(ins, s, cx); exp_flags = m_flags;
      cur_step = s; exp_valid = 1'b1;
      if (s == abort_at) begin
        @(negedge clk); #1;
        chk("rst_pre_memwrite", {15'd0, MemWrite}, 16'd1);
        exp_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_async_memwrite", {15'd0, MemWrite}, 16'd0);
        chk("rst_async_irwrite", {15'd0, IRWrite}, 16'd1);
        chk("rst_async_pcwrite", {15'd0, PCWrite}, 16'd1);
        m_flags = 4'b0000;
        break;
      end
      @(posedge clk);
      if (s == 2 && ins[27:26] == 2'b00 && cx) begin
        fw = model_flagw(ins[25:20]);
        if (fw[1]) m_flags[3:2] = af[3:2];
        if (fw[0]) m_flags[1:0] = af[1:0];
      end
      #1;
    end
    $display("instr %-6s %08h cycles=%0d condex=%0d flags=%04b", nm, ins, len, cx, m_flags);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; Instr = 20'h0; ALUFlags = 4'h0;
    #12;
    chk("reset_ctrl", got_vec, model_ctrl(32'h0, 0, 1'b0));
    chk("reset_irwrite", {15'd0, IRWrite}, 16'd1);
    chk("reset_regwrite", {15'd0, RegWrite}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr("ADD", 32'hE0821003, 4'hF, -1);
    chk("add_alu", {14'd0, seen[2][1:0]}, 16'd0);
    chk("add_rw_s2", {15'd0, seen[2][13]}, 16'd0);
    chk("add_rw_s3", {15'd0, seen[3][13]}, 16'd1);

    run_instr("LDR", 32'hE5921004, 4'hF, -1);
    chk("ldr_adrsrc", {15'd0, seen[3][11]}, 16'd1);
    chk("ldr_ressrc", {14'd0, seen[4][5:4]}, 16'd1);
    chk("ldr_rw", {15'd0, seen[4][13]}, 16'd1);

    run_instr("STR", 32'hE5821004, 4'hF, -1);
    chk("str_mw_s2", {15'd0, seen[2][14]}, 16'd0);
    chk("str_mw_s3", {15'd0, seen[3][14]}, 16'd1);

    run_instr("SUBS", 32'hE0521003, 4'b0100, -1);
    chk("subs_alu", {14'd0, seen[2][1:0]}, 16'd1);
    chk("subs_flags", {12'd0, dut.u_cond.flags_q}, 16'h0004);

    run_instr("BEQ", 32'h0A000001, 4'hF, -1);
    chk("beq_pcwrite", {15'd0, seen[2][15]}, 16'd1);

    run_instr("ADDNE", 32'h10821003, 4'hF, -1);
    chk("addne_rw", {15'd0, seen[3][13]}, 16'd0);
    chk("addne_flags", {12'd0, dut.u_cond.flags_q}, 16'h0004);

    run_instr("ADDPC", 32'hE082F003, 4'hF, -1);
    chk("addpc_pcwrite", {15'd0, seen[3][15]}, 16'd1);
    chk("addpc_rw", {15'd0, seen[3][13]}, 16'd0);

    run_instr("CMP", 32'hE1520003, 4'b0011, -1);
`ifdef CMP_NOWRITE_EN
    chk("cmp_alu", {14'd0, seen[2][1:0]}, 16'd1);
    chk("cmp_rw", {15'd0, seen[3][13]}, 16'd0);
    chk("cmp_flags", {12'd0, dut.u_cond.flags_q}, 16'h0003);
`else
    chk("cmp_alu", {14'd0, seen[2][1:0]}, 16'd0);
    chk("cmp_rw", {15'd0, seen[3][13]}, 16'd1);
    chk("cmp_flags", {12'd0, dut.u_cond.flags_q}, 16'h0004);
`endif

    run_instr("ADDI", 32'hE2821005, 4'hF, -1);
    chk("addi_srcb", {14'd0, seen[2][7:6]}, 16'd1);

    run_instr("ORRS", 32'hE1921003, 4'b1000, -1);
    chk("orrs_alu", {14'd0, seen[2][1:0]}, 16'd3);
`ifdef CMP_NOWRITE_EN
    chk("orrs_flags", {12'd0, dut.u_cond.flags_q}, 16'h000B);
`else
    chk("orrs_flags", {12'd0, dut.u_cond.flags_q}, 16'h0008);
`endif

    run_instr("AND", 32'hE0021003, 4'hF, -1);
    chk("and_alu", {14'd0, seen[2][1:0]}, 16'd2);

    run_instr("EORS", 32'hE0321003, 4'b0101, -1);
    chk("eors_alu", {14'd0, seen[2][1:0]}, 16'd0);
    chk("eors_rw", {15'd0, seen[3][13]}, 16'd1);

    run_instr("UNK", 32'hEC000000, 4'hF, -1);
    chk("unk_strobes", {12'd0, seen[2][15:12]}, 16'd0);

    run_instr("STREQ", 32'h05821004, 4'hF, -1);
    chk("streq_mw", {15'd0, seen[3][14]}, 16'd0);

    run_instr("BEQN", 32'h0A000001, 4'hF, -1);
    chk("beq_nt_pcwrite", {15'd0, seen[2][15]}, 16'd0);

    run_instr("STRRST", 32'hE5821004, 4'hF, 3);
    @(posedge clk); #1;
    chk("rst_held_ctrl", got_vec, model_ctrl(32'hE5821004, 0, 1'b0));
    reset = 1'b0;
    chk("rst_flags", {12'd0, dut.u_cond.flags_q}, 16'h0000);

    run_instr("ADD2", 32'hE0821003, 4'hF, -1);
    chk("add2_rw", {15'd0, seen[3][13]}, 16'd1);

    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
